// File: rtl/dodgypla_pkg.sv
// Shared constants and types for the PLA output filter slice.
package dodgypla_pkg;

  localparam int unsigned NUM_SEL  = 8;
  localparam logic [7:0]  SEL_IDLE = 8'hFF;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned GLITCH_W = 16;

  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [GLITCH_W-1:0] glitch_t;
  typedef logic [NUM_SEL-1:0]  sel_t;

  // Clear dominates; otherwise count up and stick at all-ones.
  function automatic glitch_t glitch_next(input glitch_t cur, input logic clr, input logic hit);
    glitch_t nxt;
    nxt = cur;
    if (clr) begin
      nxt = '0;
    end else if (hit && (cur != '1)) begin
      nxt = cur + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pla_bit_filter.sv
// One select line: two-flop synchronizer, persistence counter, output flop
// and a rejected-transient flag for the shared glitch counter.
module pla_bit_filter
  import dodgypla_pkg::*;
#(
  parameter int unsigned ASSERT_CYCLES   = 2,
  parameter int unsigned DEASSERT_CYCLES = 3,
  parameter bit          FILTER_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic f_out,
  output logic reject
);

  localparam cnt_t ASSERT_LAST   = cnt_t'(ASSERT_CYCLES - 1);
  localparam cnt_t DEASSERT_LAST = cnt_t'(DEASSERT_CYCLES - 1);

  logic sync1_q, sync1_d;
  logic s_q, s_d;
  logic f_q, f_d;
  cnt_t cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    s_d     = sync1_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    if (!FILTER_EN) begin
      // Bypass: the output flop acts as the second synchronizer stage.
      f_d   = sync1_q;
      cnt_d = '0;
    end else if (s_q == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == (s_q ? DEASSERT_LAST : ASSERT_LAST)) begin
      f_d   = s_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      s_q     <= 1'b1;
      f_q     <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
    end
  end

  assign f_out  = f_q;
  assign reject = FILTER_EN && (s_q == f_q) && (cnt_q != '0);

endmodule

// File: rtl/pla_output_filter.sv
// Deglitching filter for the eight active-low PLA select outputs, with a
// saturating count of rejected transients.
module pla_output_filter
  import dodgypla_pkg::*;
#(
  parameter int unsigned ASSERT_CYCLES   = 2,
  parameter int unsigned DEASSERT_CYCLES = 3,
  parameter logic [7:0]  FILTER_MASK     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  f_raw,
  input  logic        glitch_clr,
  output logic [7:0]  f,
  output logic [15:0] glitch_cnt
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;
  sel_t       f_bits;
  sel_t       reject;
  glitch_t    glitch_q, glitch_d;

  // Assert immediately, release two edges later so every flop leaves reset together.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  for (genvar i = 0; i < NUM_SEL; i++) begin : g_bit
    pla_bit_filter #(
      .ASSERT_CYCLES  (ASSERT_CYCLES),
      .DEASSERT_CYCLES(DEASSERT_CYCLES),
      .FILTER_EN      (FILTER_MASK[i])
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_int_n),
      .raw_in(f_raw[i]),
      .f_out (f_bits[i]),
      .reject(reject[i])
    );
  end

  always_comb begin
    glitch_d = glitch_next(glitch_q, glitch_clr, |reject);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign f          = f_bits;
  assign glitch_cnt = glitch_q;

endmodule
